// File: rtl/core_apb_bridge.sv
// core_apb_bridge: turns single core data requests into APB transfers.
// One transaction in flight; an ACCESS phase that stalls too long is
// aborted and answered with an error response.
module core_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 1..65535
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  // core data port
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  // APB requester
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Counter value seen on the last ACCESS cycle allowed before abort.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_gnt;
  logic        w_done;
  logic        w_timeout;
  logic        w_apb_active;

  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_cnt;

  // Grant is combinational; the rst term keeps it low while reset is held.
  assign w_gnt = (r_state == ST_IDLE) && data_req_i && rst;

  // Next-state decode; pready takes priority over the timeout.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    w_next    = r_state;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (w_gnt) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Capture the request on the grant cycle; held through SETUP/ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_gnt) begin
      r_addr  <= data_addr_i;
      r_we    <= data_we_i;
      r_be    <= data_be_i;
      r_wdata <= data_wdata_i;
    end
  end

  // Stall counter: cleared on SETUP entry, counts ACCESS cycles without pready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_gnt) begin
      r_cnt <= '0;
    end else if (r_state == ST_ACCESS && !pready_i) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Response capture: completer data/error, or a synthetic error on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_done) begin
      r_rdata <= r_we ? 32'h0 : prdata_i;
      r_err   <= pslverr_i;
    end else if (w_timeout) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b1;
    end
  end

  // APB address/data are only driven while a transfer is on the bus.
  assign w_apb_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = (r_state == ST_RESP);
  assign data_rdata_o  = data_rvalid_o ? r_rdata : 32'h0;
  assign data_err_o    = data_rvalid_o & r_err;

  assign psel_o    = w_apb_active;
  assign penable_o = (r_state == ST_ACCESS);
  assign paddr_o   = w_apb_active ? {r_addr[31:2], 2'b00} : 32'h0;
  assign pwrite_o  = w_apb_active & r_we;
  assign pwdata_o  = (w_apb_active && r_we) ? r_wdata : 32'h0;
  assign pstrb_o   = (w_apb_active && r_we) ? r_be : 4'b0000;

endmodule
